pipelined_barrel_right_shift: RTL and testbench
===============================================

// Module: pipelined_barrel_right_shift
//
// PURPOSE
//  Variable-amount right shifter built as a chain of fixed power-of-two shift stages.
//  Each stage is a registered, parameterized right shift by constant S = 2**k.
//  It consumes a stream of {data, shift amount, mode} over a valid/ready handshake.
//  It produces the shifted word downstream with one pipeline stage per shift-amount bit.
//  Sits in the arithmetic datapath between an operand source and a result consumer
//  (normaliser / accumulator).
//
// PARAMETERS
//  N   8             data width; power of two, N >= 2
//  SW  $clog2(N)     shift-amount width; also the number of pipeline stages (latency)
//
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       reset, synchronous, active-low (rst == 0 resets on posedge clk)
//  up_valid    in   1       upstream offers a transaction
//  up_ready    out  1       block accepts the transaction this cycle
//  up_data     in   N       operand, unsigned bit vector
//  up_shamt    in   SW      right-shift amount, 0..N-1
//  up_arith    in   1       1: fill with up_data[N-1] (arithmetic); 0: fill with zeros (logical)
//  down_valid  out  1       result available
//  down_ready  in   1       downstream takes the result this cycle
//  down_data   out  N       shifted result
//
// BEHAVIOUR
//  - Transfer on a port happens when valid && ready are both 1 at posedge clk.
//  - Stage k (k = 0..SW-1) register holds {vld_k, data_k, shamt_k, arith_k, sign_k}.
//    data_k = input to stage k, shifted right by 2**k if shamt bit k is 1, else passed
//    through unchanged.
//    Vacated top bits = sign_k if arith_k, else 0.
//    sign_k = original up_data[N-1], carried unchanged through every stage.
//  - Stage 0 input is up_data.
//    Stage k input (k > 0) is data_(k-1).
//    down_data = data_(SW-1); down_valid = vld_(SW-1).
//  - Ready chain: rdy_SW = down_ready; rdy_k = !vld_k || rdy_(k+1); up_ready = rdy_0.
//    The chain is combinational, so bubbles collapse.
//  - Stage k loads when rdy_k is 1:
//    vld_k <= (k == 0 ? up_valid : vld_(k-1)), and payload loads with it.
//    When rdy_k is 0, the stage holds its whole contents.
//  - Latency: SW cycles from up transfer to down_valid, with no stalls.
//    Throughput: 1 transaction per cycle while down_ready is 1.
//  - Capacity: SW transactions in flight.
//    With down_ready held at 0 and all stages valid, up_ready = 0.
//  - Ordering: strictly in order; no transaction is dropped or duplicated.
//  - Stall stability: while down_valid && !down_ready, down_data must stay stable.
//  - Payload with vld = 0 is don't-care; it may load freely (no gating required).
//  - Simultaneous events: down transfer and up transfer in the same cycle on a full
//    pipeline are legal. Every stage advances one position.
//  - Reset (rst == 0 at posedge): all vld_k <= 0, all data_k <= 0, so down_valid = 0
//    and down_data = 0.
//    In-flight transactions are discarded; an input offered that cycle is not accepted.
//    up_ready is 1 in the first cycle after reset, because of the combinational chain.
//  - up_shamt == 0: result equals up_data, in either mode.
//  - No X propagation: with up_valid = 0, up_data X must not make down_valid X.
//
// TESTING  (N = 8, SW = 3)
//  1. Logical: data 8'hB4, shamt 3, arith 0 -> down_data 8'h16, 3 cycles after accept.
//  2. Arithmetic: data 8'hB4, shamt 3, arith 1 -> 8'hF6.
//     Data 8'h80, shamt 7: arith 1 -> 8'hFF; arith 0 -> 8'h01.
//  3. Passthrough: data 8'h5A, shamt 0, either mode -> 8'h5A.
//  4. Streaming: 8 back-to-back transfers with shamt 0..7 of 8'hFF, logical,
//     down_ready = 1 -> outputs on 8 consecutive cycles:
//     FF, 7F, 3F, 1F, 0F, 07, 03, 01.
//  5. Backpressure: down_ready = 0 for 6 cycles under continuous up_valid.
//     -> up_ready drops after exactly 3 accepts; down_data is stable.
//     After down_ready is released, all items emerge in order, with no loss or duplicates.
//  6. Reset mid-flight: assert rst = 0 for 1 cycle with 2 items in flight.
//     -> down_valid = 0 and down_data = 0 next cycle; the old items never appear.
//     A new item is accepted the following cycle.
//  - Every scenario is also checked against a reference model: ($signed/unsigned a) >> shamt.
//    This includes randomized valid/ready toggling.

Source files
------------

// File: rtl/pipelined_barrel_right_shift.sv
// pipelined_barrel_right_shift
//
// Variable-amount right shifter built as a chain of SW registered stages.
// Stage k shifts by the constant 2**k when bit k of the shift amount is set.
// Each stage carries its transaction's shift amount, mode and original sign bit.
// A valid/ready handshake wraps the chain. The ready chain is combinational,
// so empty stages (bubbles) collapse and the pipeline streams one item per
// cycle while the consumer is ready.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-low reset
//   up_valid    upstream offers {up_data, up_shamt, up_arith}
//   up_ready    this block accepts the offer this cycle
//   up_data     N-bit operand
//   up_shamt    right-shift amount, 0..N-1
//   up_arith    1: fill vacated bits with up_data[N-1]; 0: fill with zeros
//   down_valid  a shifted result is presented
//   down_ready  downstream takes the result this cycle
//   down_data   shifted result
module pipelined_barrel_right_shift #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shamt,
  input  logic          up_arith,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

  // Per-stage registered state
  logic [SW-1:0] vld_q;
  logic [SW-1:0] arith_q;
  logic [SW-1:0] sign_q;
  logic [N-1:0]  data_q  [SW];
  logic [SW-1:0] shamt_q [SW];

  // Per-stage inputs and the shifted word each stage would capture
  logic [SW-1:0] in_vld;
  logic [SW-1:0] in_arith;
  logic [SW-1:0] in_sign;
  logic [N-1:0]  in_data  [SW];
  logic [SW-1:0] in_shamt [SW];
  logic [N-1:0]  fill     [SW];
  logic [N-1:0]  nxt_data [SW];

  // rdy[k] is 1 when stage k may load this cycle; rdy[SW] is the consumer
  logic [SW:0] rdy;

  // Ready chain, evaluated from the output end backwards. A stage can load
  // when it is empty or when the stage after it is loading as well.
  always_comb begin
    rdy     = '0;
    rdy[SW] = down_ready;
    for (int k = SW - 1; k >= 0; k--) begin
      rdy[k] = !vld_q[k] || rdy[k+1];
    end
  end

  // Stage input selection and the fixed 2**k shift of each stage. Stage 0
  // is fed from the upstream port. It also captures the operand's sign bit,
  // which every later stage carries as the arithmetic fill value.
  always_comb begin
    in_vld   = '0;
    in_arith = '0;
    in_sign  = '0;
    for (int k = 0; k < SW; k++) begin
      in_data[k]  = '0;
      in_shamt[k] = '0;
      fill[k]     = '0;
      nxt_data[k] = '0;
    end

    in_vld[0]   = up_valid;
    in_data[0]  = up_data;
    in_shamt[0] = up_shamt;
    in_arith[0] = up_arith;
    in_sign[0]  = up_data[N-1];

    for (int k = 1; k < SW; k++) begin
      in_vld[k]   = vld_q[k-1];
      in_data[k]  = data_q[k-1];
      in_shamt[k] = shamt_q[k-1];
      in_arith[k] = arith_q[k-1];
      in_sign[k]  = sign_q[k-1];
    end

    for (int k = 0; k < SW; k++) begin
      // Shifting an all-ones or all-zeros word left puts the fill into
      // exactly the 2**k vacated top positions.
      fill[k] = {N{in_arith[k] & in_sign[k]}};
      if (in_shamt[k][k]) begin
        nxt_data[k] = (in_data[k] >> (1 << k)) | (fill[k] << (N - (1 << k)));
      end else begin
        nxt_data[k] = in_data[k];
      end
    end
  end

  // Stage registers. A stage loads whenever its ready is high and holds its
  // whole contents otherwise. Payload loads together with the valid bit and
  // is not gated on it. Reset empties every stage and zeroes the data, which
  // also rejects any offer made in the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q   <= '0;
      arith_q <= '0;
      sign_q  <= '0;
      for (int k = 0; k < SW; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SW; k++) begin
        if (rdy[k]) begin
          vld_q[k]   <= in_vld[k];
          data_q[k]  <= nxt_data[k];
          shamt_q[k] <= in_shamt[k];
          arith_q[k] <= in_arith[k];
          sign_q[k]  <= in_sign[k];
        end
      end
    end
  end

  assign up_ready   = rdy[0];
  assign down_valid = vld_q[SW-1];
  assign down_data  = data_q[SW-1];

endmodule

// File: tb/tb_pipelined_barrel_right_shift.sv
// tb_pipelined_barrel_right_shift
//
// Directed bench for the pipelined barrel right shifter (N = 8, SW = 3).
// Inputs are driven 1 ns after the rising edge. Handshakes are evaluated a
// few ns later, once the combinational ready chain has settled.
module tb_pipelined_barrel_right_shift;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shamt;
  logic          up_arith;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] stream_exp [8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

  pipelined_barrel_right_shift #(.N(N), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_shamt   (up_shamt),
    .up_arith   (up_arith),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Reference: signed or unsigned shift of the whole operand
  function automatic logic [7:0] refShift(logic [7:0] a, logic [2:0] s, logic ar);
    logic signed [7:0] sa;
    sa = a;
    if (ar) return sa >>> s;
    return a >> s;
  endfunction

  function automatic logic [7:0] itemData(int i);
    return 8'(145 + i * 37);
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(logic v, logic [7:0] d, logic [2:0] s, logic a);
    up_valid = v;
    up_data  = d;
    up_shamt = s;
    up_arith = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: offer, accept, then bounded wait for the result
  task automatic sendOne(string tag, logic [7:0] d, logic [2:0] s, logic a, logic [7:0] expected);
    int lat;
    applyStimulus(1'b1, d, s, a);
    #1;
    checkOutput({tag, " up_ready"}, 32'(up_ready), 32'd1);
    step();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    lat = 1;
    while (!down_valid && lat < 10) begin
      step();
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'd3);
    checkOutput({tag, " data"}, 32'(down_data), 32'(expected));
    checkOutput({tag, " model"}, 32'(down_data), 32'(refShift(d, s, a)));
    step();
    checkOutput({tag, " drained"}, 32'(down_valid), 32'd0);
  endtask

  initial begin
    int accepts;
    int received;
    int nxt;
    logic [7:0] held;
    logic have_held;
    logic [7:0] prev_data;
    logic prev_stall;
    logic [7:0] rd;
    logic [2:0] rs;
    logic ra;

    // Reset
    rst = 1'b0;
    down_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    step();
    step();
    checkOutput("reset down_valid", 32'(down_valid), 32'd0);
    checkOutput("reset down_data", 32'(down_data), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("reset up_ready", 32'(up_ready), 32'd1);

    // X data with no valid must not reach down_valid
    up_valid = 1'b0;
    up_data  = 'x;
    up_shamt = 'x;
    up_arith = 1'bx;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("x idle down_valid", 32'(down_valid), 32'd0);
    end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    step();

    // Directed single transactions
    sendOne("logical B4>>3", 8'hB4, 3'd3, 1'b0, 8'h16);
    sendOne("arith B4>>3", 8'hB4, 3'd3, 1'b1, 8'hF6);
    sendOne("arith 80>>7", 8'h80, 3'd7, 1'b1, 8'hFF);
    sendOne("logical 80>>7", 8'h80, 3'd7, 1'b0, 8'h01);
    sendOne("pass 5A logical", 8'h5A, 3'd0, 1'b0, 8'h5A);
    sendOne("pass 5A arith", 8'h5A, 3'd0, 1'b1, 8'h5A);

    // Streaming: FF >> 0..7, one per cycle, results on 8 consecutive cycles
    for (int c = 0; c < 11; c++) begin
      if (c >= 3) begin
        checkOutput("stream valid", 32'(down_valid), 32'd1);
        checkOutput("stream data", 32'(down_data), 32'(stream_exp[c-3]));
      end else begin
        checkOutput("stream idle", 32'(down_valid), 32'd0);
      end
      if (c < 8) applyStimulus(1'b1, 8'hFF, 3'(c), 1'b0);
      else       applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
      #1;
      if (c < 8) checkOutput("stream up_ready", 32'(up_ready), 32'd1);
      step();
    end
    checkOutput("stream drained", 32'(down_valid), 32'd0);

    // Backpressure: 6 stalled cycles with continuous offers
    down_ready = 1'b0;
    accepts = 0;
    nxt = 0;
    have_held = 1'b0;
    held = 8'h00;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, itemData(nxt), 3'(nxt), nxt[0]);
      #2;
      if (up_valid && up_ready) begin
        exp_q.push_back(refShift(itemData(nxt), 3'(nxt), nxt[0]));
        nxt++;
        accepts++;
      end
      if (down_valid) begin
        if (have_held) checkOutput("bp stable", 32'(down_data), 32'(held));
        else begin
          held = down_data;
          have_held = 1'b1;
          checkOutput("bp head", 32'(down_data), 32'(exp_q[0]));
        end
      end
      step();
    end
    checkOutput("bp accepts", 32'(accepts), 32'd3);
    checkOutput("bp up_ready low", 32'(up_ready), 32'd0);
    checkOutput("bp down_valid", 32'(down_valid), 32'd1);
    checkOutput("bp stable end", 32'(down_data), 32'(held));

    down_ready = 1'b1;
    received = 0;
    for (int c = 0; c < 40 && received < 6; c++) begin
      if (nxt < 6) applyStimulus(1'b1, itemData(nxt), 3'(nxt), nxt[0]);
      else         applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
      #2;
      if (up_valid && up_ready) begin
        exp_q.push_back(refShift(itemData(nxt), 3'(nxt), nxt[0]));
        nxt++;
      end
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) checkOutput("bp extra item", 32'd1, 32'd0);
        else checkOutput("bp order", 32'(down_data), 32'(exp_q.pop_front()));
        received++;
      end
      step();
    end
    checkOutput("bp received", 32'(received), 32'd6);
    checkOutput("bp queue empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp no duplicate", 32'(down_valid), 32'd0);
      step();
    end

    // Reset with two items in flight and an offer in the reset cycle
    applyStimulus(1'b1, 8'h11, 3'd1, 1'b0);
    step();
    applyStimulus(1'b1, 8'h22, 3'd1, 1'b0);
    step();
    rst = 1'b0;
    applyStimulus(1'b1, 8'h77, 3'd0, 1'b0);
    step();
    checkOutput("midreset down_valid", 32'(down_valid), 32'd0);
    checkOutput("midreset down_data", 32'(down_data), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h3C, 3'd2, 1'b0);
    #1;
    checkOutput("midreset up_ready", 32'(up_ready), 32'd1);
    step();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    for (int l = 1; l <= 6; l++) begin
      if (l == 3) begin
        checkOutput("postreset valid", 32'(down_valid), 32'd1);
        checkOutput("postreset data", 32'(down_data), 32'h0F);
      end else begin
        checkOutput("postreset quiet", 32'(down_valid), 32'd0);
      end
      step();
    end

    // Randomized valid/ready toggling against the reference model
    exp_q.delete();
    prev_stall = 1'b0;
    prev_data = 8'h00;
    for (int c = 0; c < 300; c++) begin
      rd = 8'($urandom);
      rs = 3'($urandom_range(0, 7));
      ra = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)), rd, rs, ra);
      down_ready = 1'($urandom_range(0, 1));
      #2;
      if (prev_stall) checkOutput("rand stall stable", 32'(down_data), 32'(prev_data));
      if (up_valid && up_ready) exp_q.push_back(refShift(rd, rs, ra));
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) checkOutput("rand extra item", 32'd1, 32'd0);
        else checkOutput("rand order", 32'(down_data), 32'(exp_q.pop_front()));
      end
      prev_stall = down_valid && !down_ready;
      prev_data = down_data;
      step();
    end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    down_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      #2;
      if (down_valid) checkOutput("rand drain", 32'(down_data), 32'(exp_q.pop_front()));
      step();
    end
    checkOutput("rand queue empty", 32'(exp_q.size()), 32'd0);
    checkOutput("rand final idle", 32'(down_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
